// File: rtl/sm_colour_scan_ctrl.sv
// sm_colour_scan_ctrl: start-triggered colour-sensor measurement sequencer.
// Steps the filter select through red, green, blue (and clear when the
// SM_COLOUR_CLEAR_PHASE_EN macro is defined). Each phase is a settle gap
// followed by a counting window. The per-channel edge counts are published
// through a valid/ready handshake.
//
// Handshake: valid is high exactly while the FSM sits in DONE. A result
// transfers on any clock edge where valid and ready are both high. The
// consumer may hold ready high early, and the transfer then happens on the
// first DONE cycle. ready is ignored in every other state.
module sm_colour_scan_ctrl #(
    parameter int unsigned WINDOW = 100000,
    parameter int unsigned SETTLE = 1000
) (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic        start,
    input  logic        auto_run,
    input  logic [1:0]  scale,
    input  logic        freq,
    input  logic        ready,
    output logic        s0,
    output logic        s1,
    output logic        s2,
    output logic        s3,
    output logic        busy,
    output logic [1:0]  phase,
    output logic [15:0] count_red,
    output logic [15:0] count_green,
    output logic [15:0] count_blue,
    output logic [15:0] count_clear,
    output logic [3:0]  ovf,
    output logic        valid,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

`ifdef SM_COLOUR_CLEAR_PHASE_EN
    localparam logic [1:0] LAST_PHASE = 2'd3;
`else
    localparam logic [1:0] LAST_PHASE = 2'd2;
`endif

    // The timers load length-1 and end the state on the cycle they read zero.
    localparam logic [31:0] SETTLE_M1 = 32'(SETTLE - 1);
    localparam logic [31:0] WIN_M1    = 32'(WINDOW - 1);

    state_e            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [1:0]        scale_q, scale_d;
    logic [31:0]       timer_q, timer_d;
    logic [15:0]       work_q, work_d;
    logic [3:0]        ovf_work_q, ovf_work_d;
    logic [3:0][15:0]  shadow_q, shadow_d;
    logic [3:0][15:0]  count_q, count_d;
    logic [3:0]        ovf_q, ovf_d;
    logic [2:0]        freq_sync_q;

    logic              edge_pulse;
    logic [15:0]       work_inc;
    logic              ovf_hit;

    // Bit 0 and bit 1 form the synchroniser. Bit 2 delays one more cycle
    // so that a rising edge can be detected.
    assign edge_pulse = freq_sync_q[1] & ~freq_sync_q[2];

    // Saturating increment of the working counter for this cycle's edge pulse.
    always_comb begin
        work_inc = work_q;
        ovf_hit  = 1'b0;
        if (edge_pulse) begin
            if (work_q == 16'hFFFF) begin
                ovf_hit = 1'b1;
            end else begin
                work_inc = work_q + 16'd1;
            end
        end
    end

    // Next-state logic for the sequencer, the timers and the result registers.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        scale_d    = scale_q;
        timer_d    = timer_q;
        work_d     = work_q;
        ovf_work_d = ovf_work_q;
        shadow_d   = shadow_q;
        count_d    = count_q;
        ovf_d      = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SETTLE;
                    phase_d    = 2'd0;
                    scale_d    = scale;
                    timer_d    = SETTLE_M1;
                    work_d     = 16'd0;
                    ovf_work_d = 4'd0;
                end
            end
            ST_SETTLE: begin
                // Edge pulses are dropped here because work_d is not touched.
                if (timer_q == 32'd0) begin
                    state_d = ST_COUNT;
                    timer_d = WIN_M1;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            ST_COUNT: begin
                work_d = work_inc;
                if (ovf_hit) begin
                    ovf_work_d[phase_q] = 1'b1;
                end
                if (timer_q == 32'd0) begin
                    // The final window cycle's pulse is included through work_inc.
                    shadow_d[phase_q] = work_inc;
                    work_d            = 16'd0;
                    if (phase_q == LAST_PHASE) begin
                        state_d = ST_DONE;
                        count_d = shadow_d;
                        ovf_d   = ovf_work_d;
                    end else begin
                        state_d = ST_SETTLE;
                        phase_d = phase_q + 2'd1;
                        timer_d = SETTLE_M1;
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            ST_DONE: begin
                if (ready) begin
                    if (auto_run) begin
                        state_d    = ST_SETTLE;
                        phase_d    = 2'd0;
                        scale_d    = scale;
                        timer_d    = SETTLE_M1;
                        work_d     = 16'd0;
                        ovf_work_d = 4'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers, with synchronous active-low reset.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= 2'd0;
            scale_q     <= 2'b11;
            timer_q     <= 32'd0;
            work_q      <= 16'd0;
            ovf_work_q  <= 4'd0;
            shadow_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 4'd0;
            freq_sync_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            scale_q     <= scale_d;
            timer_q     <= timer_d;
            work_q      <= work_d;
            ovf_work_q  <= ovf_work_d;
            shadow_q    <= shadow_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            freq_sync_q <= {freq_sync_q[1:0], freq};
        end
    end

    // Filter select decode: red 00, green 11, blue 01, clear 10.
    always_comb begin
        s2 = 1'b0;
        s3 = 1'b0;
        case (phase_q)
            2'd1:    begin s2 = 1'b1; s3 = 1'b1; end
            2'd2:    begin s2 = 1'b0; s3 = 1'b1; end
            2'd3:    begin s2 = 1'b1; s3 = 1'b0; end
            default: begin s2 = 1'b0; s3 = 1'b0; end
        endcase
    end

    assign s0          = scale_q[1];
    assign s1          = scale_q[0];
    assign busy        = (state_q != ST_IDLE);
    assign valid       = (state_q == ST_DONE);
    assign phase       = phase_q;
    assign dbg_state   = state_q;
    assign count_red   = count_q[0];
    assign count_green = count_q[1];
    assign count_blue  = count_q[2];
    assign count_clear = count_q[3];
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_sm_colour_scan_ctrl.sv
// Directed testbench for sm_colour_scan_ctrl with WINDOW=100 and SETTLE=10.
module tb_sm_colour_scan_ctrl;

    localparam int unsigned WINDOW = 100;
    localparam int unsigned SETTLE = 10;

    logic        clk_50;
    logic        rst_n;
    logic        start;
    logic        auto_run;
    logic [1:0]  scale;
    logic        freq;
    logic        ready;
    logic        s0, s1, s2, s3;
    logic        busy;
    logic [1:0]  phase;
    logic [15:0] count_red, count_green, count_blue, count_clear;
    logic [3:0]  ovf;
    logic        valid;
    logic [1:0]  dbg_state;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_q[$];

    int          freq_per = 0;
    logic        freq_man = 1'b0;
    int          fcnt     = 0;

    sm_colour_scan_ctrl #(.WINDOW(WINDOW), .SETTLE(SETTLE)) dut (
        .clk_50      (clk_50),
        .rst_n       (rst_n),
        .start       (start),
        .auto_run    (auto_run),
        .scale       (scale),
        .freq        (freq),
        .ready       (ready),
        .s0          (s0),
        .s1          (s1),
        .s2          (s2),
        .s3          (s3),
        .busy        (busy),
        .phase       (phase),
        .count_red   (count_red),
        .count_green (count_green),
        .count_blue  (count_blue),
        .count_clear (count_clear),
        .ovf         (ovf),
        .valid       (valid),
        .dbg_state   (dbg_state)
    );

    // Clock and reset block
    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Sensor model: a square wave of freq_per cycles, or freq_man when freq_per is 0.
    initial begin
        freq = 1'b0;
        forever begin
            @(negedge clk_50);
            if (freq_per != 0) begin
                fcnt = (fcnt + 1) % freq_per;
                freq = (fcnt < freq_per / 2);
            end else begin
                freq = freq_man;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Driver tasks
    task automatic cyc(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_50);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        while (!valid && waited < budget) begin
            @(negedge clk_50);
            waited++;
        end
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, output int waited);
        waited = 0;
        while (dbg_state != st && waited < budget) begin
            @(negedge clk_50);
            waited++;
        end
    endtask

    task automatic inject_two_edges();
        freq_man = 1'b1; cyc(1);
        freq_man = 1'b0; cyc(1);
        freq_man = 1'b1; cyc(1);
        freq_man = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, " red"},   count_red,   exp_q.pop_front());
        check({tag, " green"}, count_green, exp_q.pop_front());
        check({tag, " blue"},  count_blue,  exp_q.pop_front());
    endtask

    initial begin
        int k;
        int w;
        int hits;

        rst_n = 1'b0; start = 1'b0; auto_run = 1'b0; scale = 2'b00; ready = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);

        // Reset values and idle behaviour
        check("rst state", dbg_state, 2'd0);
        check("rst busy", busy, 1'b0);
        check("rst phase", phase, 2'd0);
        check("rst s2s3", {s2, s3}, 2'b00);
        check("rst s0s1", {s0, s1}, 2'b11);
        check("rst counts", {count_red, count_green, count_blue, count_clear}, 64'd0);
        check("rst ovf", ovf, 4'd0);
        hits = 0;
        for (int i = 0; i < 1000; i++) begin
            if (valid || busy) hits++;
            cyc(1);
        end
        check("idle no valid", hits, 0);

        // Normal sequence with a period-10 square wave, ready held low
        freq_per = 10; scale = 2'b10;
        cyc(20);
        pulse_start();
        check("start state", dbg_state, 2'd1);
        check("start busy", busy, 1'b1);
        check("start s0s1", {s0, s1}, 2'b10);
        check("red s2s3", {s2, s3}, 2'b00);
        k = 0;
        while (!valid && k < 400) begin
            if (k == 115) begin
                check("green phase", phase, 2'd1);
                check("green s2s3", {s2, s3}, 2'b11);
            end
            if (k == 225) begin
                check("blue phase", phase, 2'd2);
                check("blue s2s3", {s2, s3}, 2'b01);
            end
            cyc(1);
            k++;
        end
        check("valid latency", k, 330);
        exp_q.push_back(16'd10); exp_q.push_back(16'd10); exp_q.push_back(16'd10);
        check_counts("seq1");
        check("seq1 clear", count_clear, 16'd0);
        check("seq1 ovf", ovf, 4'd0);

        // ready low for 50 cycles: valid holds, start is ignored
        hits = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) start = 1'b1;
            if (i == 21) start = 1'b0;
            if (!valid) hits++;
            cyc(1);
        end
        check("valid held", hits, 0);
        check("held state", dbg_state, 2'd3);
        ready = 1'b1;
        cyc(1);
        check("hs valid low", valid, 1'b0);
        check("hs idle", dbg_state, 2'd0);
        check("hs busy", busy, 1'b0);
        ready = 1'b0;

        // Edges only in SETTLE gaps must not be counted
        freq_per = 0; freq_man = 1'b0;
        cyc(5);
        pulse_start();
        inject_two_edges();
        wait_state(2'd2, 200, w);
        wait_state(2'd1, 200, w);
        inject_two_edges();
        wait_state(2'd2, 200, w);
        wait_state(2'd1, 200, w);
        inject_two_edges();
        wait_valid(400, w);
        check("settle valid", valid, 1'b1);
        exp_q.push_back(16'd0); exp_q.push_back(16'd0); exp_q.push_back(16'd0);
        check_counts("settle");
        check("settle ovf", ovf, 4'd0);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;

        // Back-to-back sequences, then reset mid-green
        freq_per = 10; auto_run = 1'b1; ready = 1'b1; scale = 2'b01;
        cyc(5);
        pulse_start();
        check("auto s0s1", {s0, s1}, 2'b01);
        wait_valid(400, w);
        check("auto first valid", w, 330);
        cyc(1);
        check("auto valid pulse", valid, 1'b0);
        check("auto restart", dbg_state, 2'd1);
        wait_valid(400, w);
        check("auto period", w + 1, 331);
        exp_q.push_back(16'd10); exp_q.push_back(16'd10); exp_q.push_back(16'd10);
        check_counts("auto");
        k = 0;
        while (phase != 2'd1 && k < 400) begin
            cyc(1);
            k++;
        end
        check("reach green", phase, 2'd1);
        cyc(20);
        rst_n = 1'b0;
        cyc(1);
        check("mid rst state", dbg_state, 2'd0);
        check("mid rst busy", busy, 1'b0);
        check("mid rst phase", phase, 2'd0);
        check("mid rst valid", valid, 1'b0);
        check("mid rst s0s1", {s0, s1}, 2'b11);
        check("mid rst s2s3", {s2, s3}, 2'b00);
        check("mid rst counts", {count_red, count_green, count_blue, count_clear}, 64'd0);
        check("mid rst ovf", ovf, 4'd0);
        rst_n = 1'b1; auto_run = 1'b0; ready = 1'b0;
        hits = 0;
        for (int i = 0; i < 400; i++) begin
            if (valid) hits++;
            cyc(1);
        end
        check("no partial valid", hits, 0);

`ifdef SM_COLOUR_CLEAR_PHASE_EN
        // Four-phase sequence with a period-4 square wave
        freq_per = 4;
        cyc(5);
        pulse_start();
        k = 0;
        while (!valid && k < 600) begin
            if (k == 335) begin
                check("clear phase", phase, 2'd3);
                check("clear s2s3", {s2, s3}, 2'b10);
            end
            cyc(1);
            k++;
        end
        check("clr latency", k, 440);
        exp_q.push_back(16'd25); exp_q.push_back(16'd25); exp_q.push_back(16'd25);
        check_counts("clr");
        check("clr clear", count_clear, 16'd25);
        check("clr ovf", ovf, 4'd0);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
